// File: rtl/display_source_scheduler_if.sv
// -----------------------------------------------------------------------------
// display_source_scheduler_if
//
// Bundle of the source/request side and the display side of the display
// source scheduler. The clock and reset are not part of the bundle.
//
// Signals:
//   src_data   NUM_SRC*DISPLAY_WIDTH  packed source words, source i at
//                                     [i*DISPLAY_WIDTH +: DISPLAY_WIDTH]
//   src_valid  NUM_SRC                source i may be displayed
//   btn_next   1                      raw asynchronous push-button, active-high
//   auto_en    1                      1 = AUTO mode requested, 0 = MANUAL
//   freeze     1                      hold display value, pause dwell timer
//   display    DISPLAY_WIDTH          registered word to the hex display driver
//   sel_idx    $clog2(NUM_SRC)        index of the currently selected source
//   auto_mode  1                      1 while the scheduler is in AUTO
//
// Modports:
//   master  drives the requests/controls and observes the display side
//   slave   the scheduler itself
// -----------------------------------------------------------------------------
interface display_source_scheduler_if #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned DISPLAY_WIDTH = 32
);
    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC*DISPLAY_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]               src_valid;
    logic                             btn_next;
    logic                             auto_en;
    logic                             freeze;
    logic [DISPLAY_WIDTH-1:0]         display;
    logic [IDX_W-1:0]                 sel_idx;
    logic                             auto_mode;

    modport master (
        output src_data,
        output src_valid,
        output btn_next,
        output auto_en,
        output freeze,
        input  display,
        input  sel_idx,
        input  auto_mode
    );

    modport slave (
        input  src_data,
        input  src_valid,
        input  btn_next,
        input  auto_en,
        input  freeze,
        output display,
        output sel_idx,
        output auto_mode
    );
endinterface

// File: rtl/display_source_scheduler.sv
// -----------------------------------------------------------------------------
// display_source_scheduler
//
// Shares one DISPLAY_WIDTH-bit seven-segment display word between NUM_SRC
// requesters (PC, instruction, selected register, debug word, ...). The word
// goes to an 8-digit hex display driver, nibble k on digit k.
//
//   AUTO   : rotates through the valid sources, each shown for DWELL_CYCLES.
//   MANUAL : steps to the next valid source on each debounced button press.
//   freeze : holds the displayed value and pauses the dwell timer; presses
//            still move the selection so the new source shows on release.
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-low (sampled on posedge clk)
//   bus   display_source_scheduler_if.slave (sources, controls, display side)
//
// Timing: display follows sel_idx with one cycle of latency.
// -----------------------------------------------------------------------------
module display_source_scheduler #(
    parameter int unsigned NUM_SRC         = 4,
    parameter int unsigned DISPLAY_WIDTH   = 32,
    parameter int unsigned DWELL_CYCLES    = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    display_source_scheduler_if.slave   bus
);

    localparam int unsigned IDX_W   = $clog2(NUM_SRC);
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 32'd1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(32'd1);
    localparam logic [DWELL_W-1:0] DWELL_ZERO = DWELL_W'(32'd0);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(32'd1);
    localparam logic [DEB_W-1:0]   DEB_ZERO   = DEB_W'(32'd0);

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Next-valid-source search: looks at sel+1, sel+2, ... wrapping modulo
    // NUM_SRC and finishing on sel itself. With no valid source at all the
    // selection is left where it is.
    // -------------------------------------------------------------------------
    function automatic logic [IDX_W-1:0] next_valid(
        input logic [IDX_W-1:0]   sel,
        input logic [NUM_SRC-1:0] valid
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      cand;
        pick  = sel;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = (32'(sel) + k) % NUM_SRC;
            if (!found && valid[cand[IDX_W-1:0]]) begin
                pick  = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Button path
    logic               sync1_r;
    logic               sync2_r;
    logic               deb_level_r;
    logic [DEB_W-1:0]   deb_cnt_r;
    logic               press_r;

    // Scheduler state
    state_t             state_r;
    state_t             state_nxt_s;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] dwell_nxt_s;
    logic [IDX_W-1:0]   sel_r;
    logic [IDX_W-1:0]   sel_nxt_s;
    logic [DISPLAY_WIDTH-1:0] display_r;

    // Helpers
    logic [DISPLAY_WIDTH-1:0] words_s [NUM_SRC];
    logic [IDX_W-1:0]   nxt_idx_s;
    logic               cur_valid_s;
    logic               mode_change_s;
    logic               timeout_s;
    logic               advance_s;

    // Unpack the flat source bus into one word per source.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign words_s[i] = bus.src_data[i*DISPLAY_WIDTH +: DISPLAY_WIDTH];
    end

    assign nxt_idx_s   = next_valid(sel_r, bus.src_valid);
    assign cur_valid_s = bus.src_valid[sel_r];

    // Synchronise the raw button, debounce it and emit a pulse on each press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            deb_level_r <= 1'b0;
            deb_cnt_r   <= DEB_ZERO;
            press_r     <= 1'b0;
        end else begin
            sync1_r <= bus.btn_next;
            sync2_r <= sync1_r;
            if (sync2_r != deb_level_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    // Stable long enough: accept the new level. Only a
                    // rising acceptance counts as a press.
                    deb_level_r <= sync2_r;
                    deb_cnt_r   <= DEB_ZERO;
                    press_r     <= sync2_r;
                end else begin
                    deb_cnt_r   <= deb_cnt_r + DEB_ONE;
                    press_r     <= 1'b0;
                end
            end else begin
                deb_cnt_r <= DEB_ZERO;
                press_r   <= 1'b0;
            end
        end
    end

    // Mode FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_AUTO;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Mode FSM next state: follows the requested mode directly.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_AUTO: begin
                if (bus.auto_en) begin
                    state_nxt_s = ST_AUTO;
                end else begin
                    state_nxt_s = ST_MANUAL;
                end
            end
            ST_MANUAL: begin
                if (bus.auto_en) begin
                    state_nxt_s = ST_AUTO;
                end else begin
                    state_nxt_s = ST_MANUAL;
                end
            end
            default: begin
                state_nxt_s = ST_AUTO;
            end
        endcase
    end

    // Mode FSM outputs: next selection and next dwell count.
    always_comb begin
        mode_change_s = (state_nxt_s != state_r);
        timeout_s     = 1'b0;
        advance_s     = 1'b0;
        sel_nxt_s     = sel_r;
        dwell_nxt_s   = dwell_r;

        // The mode change wins over the timer: a cycle that switches modes
        // restarts the dwell instead of timing out.
        case (state_r)
            ST_AUTO: begin
                timeout_s = !bus.freeze && !mode_change_s && (dwell_r == DWELL_LAST);
            end
            ST_MANUAL: begin
                timeout_s = 1'b0;
            end
            default: begin
                timeout_s = 1'b0;
            end
        endcase

        // Press, timeout and repair of an invalid selection all collapse
        // into one single advance. Presses still count while frozen.
        advance_s = press_r || timeout_s || (!bus.freeze && !cur_valid_s);

        if (advance_s) begin
            sel_nxt_s = nxt_idx_s;
        end else begin
            sel_nxt_s = sel_r;
        end

        if (mode_change_s) begin
            dwell_nxt_s = DWELL_ZERO;
        end else if (state_r == ST_MANUAL) begin
            dwell_nxt_s = DWELL_ZERO;
        end else if (bus.freeze) begin
            dwell_nxt_s = dwell_r;
        end else if (advance_s) begin
            dwell_nxt_s = DWELL_ZERO;
        end else begin
            dwell_nxt_s = dwell_r + DWELL_ONE;
        end
    end

    // Selection, dwell timer and display word registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_r     <= {IDX_W{1'b0}};
            dwell_r   <= DWELL_ZERO;
            display_r <= {DISPLAY_WIDTH{1'b0}};
        end else begin
            sel_r   <= sel_nxt_s;
            dwell_r <= dwell_nxt_s;
            // An invalid selection keeps the last good word on the display
            // for the one cycle it takes to move to the next valid source.
            if (!bus.freeze && cur_valid_s) begin
                display_r <= words_s[sel_r];
            end else begin
                display_r <= display_r;
            end
        end
    end

    assign bus.display   = display_r;
    assign bus.sel_idx   = sel_r;
    assign bus.auto_mode = state_r;

endmodule
